// File: rtl/strip_trig_pkg.sv
// Purpose : shared widths, frame-field offsets, FSM state type and parity helper
//           for the strip trigger serial-link receiver.
// Latency : n/a (declarations only).  Backpressure: n/a.
package strip_trig_pkg;

    localparam int BCID_W          = 12;
    localparam int PHI_W           = 5;
    localparam int BAND_W          = 8;
    localparam int FRAME_PAIRS_DEF = 13;
    localparam int FRAME_W         = BCID_W + PHI_W + BAND_W + 1;  // 26

    // Field positions inside the received frame word; bit 0 carries parity.
    localparam int PAR_LSB  = 0;
    localparam int BAND_LSB = 1;
    localparam int PHI_LSB  = BAND_LSB + BAND_W;  // 9
    localparam int BCID_LSB = PHI_LSB + PHI_W;    // 14

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFT    = 2'd1,
        CHECK    = 2'd2,
        WAIT_LOW = 2'd3
    } state_e;

    // The parity bit makes the whole word carry an even number of ones,
    // so a good word XOR-reduces to zero.
    function automatic logic parity_ok(input logic [FRAME_W-1:0] w);
        return ~(^w);
    endfunction

endpackage

// File: rtl/strip_trigger_info_receiver_if.sv
// Purpose : link lines plus decoded result/status bus of the strip trigger receiver.
// Latency : n/a (wires only).  Backpressure: none; the link has no flow control.
// Ports   : slave = receiver (samples trig_*, drives results), master = link source / consumer.
interface strip_trigger_info_receiver_if #(
    parameter int CNT_WIDTH = 16
);
    import strip_trig_pkg::*;

    logic                 trig_clk;
    logic                 trig_en;
    logic                 trig_d0;
    logic                 trig_d1;

    logic [BCID_W-1:0]    bcid;
    logic [PHI_W-1:0]     phi_id;
    logic [BAND_W-1:0]    band_id;
    logic                 data_valid;
    logic                 parity_err;
    logic                 length_err;
    logic                 overrun_err;
    logic                 timeout_err;
    logic [CNT_WIDTH-1:0] frame_cnt;
    logic [CNT_WIDTH-1:0] err_cnt;

    modport slave (
        input  trig_clk, trig_en, trig_d0, trig_d1,
        output bcid, phi_id, band_id, data_valid,
               parity_err, length_err, overrun_err, timeout_err,
               frame_cnt, err_cnt
    );

    modport master (
        output trig_clk, trig_en, trig_d0, trig_d1,
        input  bcid, phi_id, band_id, data_valid,
               parity_err, length_err, overrun_err, timeout_err,
               frame_cnt, err_cnt
    );

endinterface

// File: rtl/strip_trig_rx_sync.sv
// Purpose : synchronize trig_clk/en/d0/d1 into clk and emit a one-cycle strobe on trig_clk rising.
// Latency : strobe and sampled en/d0/d1 appear STAGES+1 clk cycles after trig_clk rises at the pin.
// Backpressure: none; every rising edge produces exactly one strobe.
// Ports   : clk, reset (sync, active-high); trig_*_i raw lines; strobe_o, en_s_o, d0_s_o, d1_s_o.
module strip_trig_rx_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic trig_clk_i,
    input  logic trig_en_i,
    input  logic trig_d0_i,
    input  logic trig_d1_i,
    output logic strobe_o,
    output logic en_s_o,
    output logic d0_s_o,
    output logic d1_s_o
);

    // Line order inside each stage: {trig_clk, en, d1, d0}.
    logic [STAGES-1:0][3:0] sync_q;
    logic                   clk_prev_q;
    logic                   strobe_q;
    logic                   en_q;
    logic                   d0_q;
    logic                   d1_q;
    logic [3:0]             last_stage;

    assign last_stage = sync_q[STAGES-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q     <= '0;
            clk_prev_q <= 1'b0;
            strobe_q   <= 1'b0;
            en_q       <= 1'b0;
            d0_q       <= 1'b0;
            d1_q       <= 1'b0;
        end else begin
            sync_q     <= {sync_q[STAGES-2:0], {trig_clk_i, trig_en_i, trig_d1_i, trig_d0_i}};
            clk_prev_q <= last_stage[3];
            // Data is taken from the same stage that shows the edge, so it is
            // aligned with the strobe regardless of per-line skew downstream.
            strobe_q   <= last_stage[3] & ~clk_prev_q;
            en_q       <= last_stage[2];
            d1_q       <= last_stage[1];
            d0_q       <= last_stage[0];
        end
    end

    assign strobe_o = strobe_q;
    assign en_s_o   = en_q;
    assign d0_s_o   = d0_q;
    assign d1_s_o   = d1_q;

endmodule

// File: rtl/strip_trigger_info_receiver.sv
// Purpose : strip trigger link receiver: frame FSM, shift register, parity/length checks, counters.
// Latency : data_valid/parity_err 1 clk after the final-pair strobe; timeout_err TIMEOUT clk after last strobe.
// Backpressure: none; results are one-cycle pulses, fields hold until the next good frame.
// Ports   : clk, reset (sync, active-high); link (slave modport) carries trig_* in and all results out.
module strip_trigger_info_receiver
    import strip_trig_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FRAME_PAIRS = FRAME_PAIRS_DEF,
    parameter int TIMEOUT     = 64,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    strip_trigger_info_receiver_if.slave  link
);

    localparam int PAIR_W = $clog2(FRAME_PAIRS + 1);
    localparam int TMO_W  = $clog2(TIMEOUT + 1);

    logic strobe, en_s, d0_s, d1_s;

    strip_trig_rx_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk        (clk),
        .reset      (reset),
        .trig_clk_i (link.trig_clk),
        .trig_en_i  (link.trig_en),
        .trig_d0_i  (link.trig_d0),
        .trig_d1_i  (link.trig_d1),
        .strobe_o   (strobe),
        .en_s_o     (en_s),
        .d0_s_o     (d0_s),
        .d1_s_o     (d1_s)
    );

    state_e               state_q, state_d;
    logic [FRAME_W-1:0]   sr_q, sr_d, sr_shift;
    logic [PAIR_W-1:0]    pair_q, pair_d;
    logic [TMO_W-1:0]     tmo_q, tmo_d;
    logic                 ovr_seen_q, ovr_seen_d;
    logic [BCID_W-1:0]    bcid_q, bcid_d;
    logic [PHI_W-1:0]     phi_q, phi_d;
    logic [BAND_W-1:0]    band_q, band_d;
    logic                 valid_q, valid_d;
    logic                 par_err_q, par_err_d;
    logic                 len_err_q, len_err_d;
    logic                 ovr_err_q, ovr_err_d;
    logic                 tmo_err_q, tmo_err_d;
    logic [CNT_WIDTH-1:0] frame_cnt_q, frame_cnt_d;
    logic [CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
    logic                 any_err;

    // First pair received ends up in the MSBs after the full frame.
    assign sr_shift = {sr_q[FRAME_W-3:0], d1_s, d0_s};
    assign any_err  = par_err_d | len_err_d | ovr_err_d | tmo_err_d;

    always_comb begin
        state_d    = state_q;
        sr_d       = sr_q;
        pair_d     = pair_q;
        tmo_d      = tmo_q;
        ovr_seen_d = ovr_seen_q;
        bcid_d     = bcid_q;
        phi_d      = phi_q;
        band_d     = band_q;
        valid_d    = 1'b0;
        par_err_d  = 1'b0;
        len_err_d  = 1'b0;
        ovr_err_d  = 1'b0;
        tmo_err_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                tmo_d      = '0;
                ovr_seen_d = 1'b0;
                if (strobe && en_s) begin
                    sr_d    = sr_shift;
                    pair_d  = PAIR_W'(1);
                    tmo_d   = TMO_W'(1);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (strobe) begin
                    // tmo counts clk cycles elapsed since the last strobe.
                    tmo_d = TMO_W'(1);
                    if (en_s) begin
                        sr_d   = sr_shift;
                        pair_d = pair_q + 1'b1;
                        if (pair_q == PAIR_W'(FRAME_PAIRS - 1)) begin
                            // Check result is registered on entry so the pulse
                            // and fields are presented during the CHECK cycle.
                            state_d = CHECK;
                            if (parity_ok(sr_shift)) begin
                                valid_d = 1'b1;
                                bcid_d  = sr_shift[BCID_LSB +: BCID_W];
                                phi_d   = sr_shift[PHI_LSB  +: PHI_W];
                                band_d  = sr_shift[BAND_LSB +: BAND_W];
                            end else begin
                                par_err_d = 1'b1;
                            end
                        end
                    end else begin
                        len_err_d = 1'b1;
                        state_d   = IDLE;
                    end
                end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                    tmo_err_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            CHECK: begin
                state_d = WAIT_LOW;
            end
            WAIT_LOW: begin
                if (strobe) begin
                    if (en_s) begin
                        ovr_err_d  = ~ovr_seen_q;
                        ovr_seen_d = 1'b1;
                    end else begin
                        ovr_seen_d = 1'b0;
                        state_d    = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        frame_cnt_d = frame_cnt_q;
        if (valid_d && (frame_cnt_q != '1)) frame_cnt_d = frame_cnt_q + 1'b1;
        err_cnt_d = err_cnt_q;
        if (any_err && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            sr_q        <= '0;
            pair_q      <= '0;
            tmo_q       <= '0;
            ovr_seen_q  <= 1'b0;
            bcid_q      <= '0;
            phi_q       <= '0;
            band_q      <= '0;
            valid_q     <= 1'b0;
            par_err_q   <= 1'b0;
            len_err_q   <= 1'b0;
            ovr_err_q   <= 1'b0;
            tmo_err_q   <= 1'b0;
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            pair_q      <= pair_d;
            tmo_q       <= tmo_d;
            ovr_seen_q  <= ovr_seen_d;
            bcid_q      <= bcid_d;
            phi_q       <= phi_d;
            band_q      <= band_d;
            valid_q     <= valid_d;
            par_err_q   <= par_err_d;
            len_err_q   <= len_err_d;
            ovr_err_q   <= ovr_err_d;
            tmo_err_q   <= tmo_err_d;
            frame_cnt_q <= frame_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign link.bcid        = bcid_q;
    assign link.phi_id      = phi_q;
    assign link.band_id     = band_q;
    assign link.data_valid  = valid_q;
    assign link.parity_err  = par_err_q;
    assign link.length_err  = len_err_q;
    assign link.overrun_err = ovr_err_q;
    assign link.timeout_err = tmo_err_q;
    assign link.frame_cnt   = frame_cnt_q;
    assign link.err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_strip_trigger_info_receiver.sv
// Purpose : scoreboard bench for the strip trigger receiver; directed frames at trig_clk = clk/8.
// Latency : expects result pulses 4 clk after the trig_clk pin rise (3 sync+strobe, 1 FSM).
// Backpressure: n/a.
module tb_strip_trigger_info_receiver;
    import strip_trig_pkg::*;

    localparam int CW = 4;
    localparam logic [25:0] W_GOOD = 26'h2AF2AB4;  // {0xABC, 0x15, 0x5A, parity 0}

    typedef enum int {EV_VALID = 0, EV_PAR = 1, EV_LEN = 2, EV_OVR = 3, EV_TMO = 4} ev_e;
    typedef struct {
        int          kind;
        int          cyc;
        logic [11:0] bcid;
        logic [4:0]  phi;
        logic [7:0]  band;
        int          fcnt;
        int          ecnt;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    strip_trigger_info_receiver_if #(.CNT_WIDTH(CW)) bus ();

    strip_trigger_info_receiver #(
        .SYNC_STAGES (2),
        .FRAME_PAIRS (13),
        .TIMEOUT     (64),
        .CNT_WIDTH   (CW)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .link  (bus)
    );

    exp_t        sb[$];
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;
    int          last_rise = 0;
    logic [11:0] m_bcid = '0;
    logic [4:0]  m_phi  = '0;
    logic [7:0]  m_band = '0;
    int          m_fcnt = 0;
    int          m_ecnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected event with the model state it leaves behind.
    task automatic push_ev(input int kind, input int at, input logic [11:0] b,
                           input logic [4:0] p, input logic [7:0] n);
        exp_t e;
        if (kind == EV_VALID) begin
            m_bcid = b; m_phi = p; m_band = n;
            if (m_fcnt < 15) m_fcnt++;
        end else begin
            if (m_ecnt < 15) m_ecnt++;
        end
        e.kind = kind; e.cyc = at;
        e.bcid = m_bcid; e.phi = m_phi; e.band = m_band;
        e.fcnt = m_fcnt; e.ecnt = m_ecnt;
        sb.push_back(e);
    endtask

    // Monitor: pops one expectation per observed pulse.
    always @(negedge clk) begin
        if (!reset) begin
            int   n;
            int   act_kind;
            exp_t e;
            n = 32'(bus.data_valid) + 32'(bus.parity_err) + 32'(bus.length_err)
              + 32'(bus.overrun_err) + 32'(bus.timeout_err);
            act_kind = bus.data_valid ? EV_VALID : bus.parity_err ? EV_PAR :
                       bus.length_err ? EV_LEN : bus.overrun_err ? EV_OVR : EV_TMO;
            if (n > 1) check("single_pulse", 32'(n), 32'd1);
            if (n > 0) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_pulse actual kind=%0d required none (cyc %0d)", act_kind, cyc);
                end else begin
                    e = sb.pop_front();
                    check("ev_kind",   32'(act_kind),      32'(e.kind));
                    check("ev_cycle",  32'(cyc),           32'(e.cyc));
                    check("bcid",      32'(bus.bcid),      32'(e.bcid));
                    check("phi_id",    32'(bus.phi_id),    32'(e.phi));
                    check("band_id",   32'(bus.band_id),   32'(e.band));
                    check("frame_cnt", 32'(bus.frame_cnt), 32'(e.fcnt));
                    check("err_cnt",   32'(bus.err_cnt),   32'(e.ecnt));
                end
            end
        end
    end

    // Low phase with new data, then the rising edge; returns at the rise.
    task automatic rise_pair(input logic d1, input logic d0, input logic en);
        @(negedge clk);
        bus.trig_clk = 1'b0; bus.trig_en = en; bus.trig_d1 = d1; bus.trig_d0 = d0;
        repeat (3) @(negedge clk);
        bus.trig_clk = 1'b1;
        last_rise = cyc;
    endtask

    task automatic hold_high();
        repeat (3) @(negedge clk);
    endtask

    function automatic logic [25:0] mkword(input logic [11:0] b, input logic [4:0] p,
                                           input logic [7:0] n);
        return {b, p, n, ^{b, p, n}};
    endfunction

    // n_en strobes with en=1; tail sends a closing en=0 strobe, otherwise the link goes quiet.
    task automatic frame(input logic [25:0] w, input int n_en, input bit tail,
                         input logic [11:0] b, input logic [4:0] p, input logic [7:0] n);
        logic [1:0] pr;
        for (int i = 0; i < n_en; i++) begin
            pr = (i < 13) ? w[25 - 2*i -: 2] : 2'b11;
            rise_pair(pr[1], pr[0], 1'b1);
            if (i == 12) push_ev(parity_ok(w) ? EV_VALID : EV_PAR, last_rise + 4, b, p, n);
            if (i == 13) push_ev(EV_OVR, last_rise + 4, b, p, n);
            hold_high();
        end
        if (tail) begin
            rise_pair(1'b0, 1'b0, 1'b0);
            if (n_en < 13) push_ev(EV_LEN, last_rise + 4, b, p, n);
            hold_high();
        end else begin
            push_ev(EV_TMO, last_rise + 67, b, p, n);
            @(negedge clk);
            bus.trig_clk = 1'b0;
            repeat (90) @(negedge clk);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_bcid"},  32'(bus.bcid),      32'd0);
        check({tag, "_phi"},   32'(bus.phi_id),    32'd0);
        check({tag, "_band"},  32'(bus.band_id),   32'd0);
        check({tag, "_pulse"}, 32'({bus.data_valid, bus.parity_err, bus.length_err,
                                    bus.overrun_err, bus.timeout_err}), 32'd0);
        check({tag, "_fcnt"},  32'(bus.frame_cnt), 32'd0);
        check({tag, "_ecnt"},  32'(bus.err_cnt),   32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [25:0] w;
        bus.trig_clk = 1'b0; bus.trig_en = 1'b0; bus.trig_d0 = 1'b0; bus.trig_d1 = 1'b0;
        repeat (4) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // Good frame, then the same frame with the parity bit inverted.
        frame(W_GOOD, 13, 1'b1, 12'hABC, 5'h15, 8'h5A);
        frame(W_GOOD ^ 26'h1, 13, 1'b1, 12'h000, 5'h00, 8'h00);

        // Early en drop after 7 pairs, then a good frame.
        frame(26'h3FFFFFF, 7, 1'b1, 12'h000, 5'h00, 8'h00);
        w = mkword(12'h123, 5'h0A, 8'hC3);
        frame(w, 13, 1'b1, 12'h123, 5'h0A, 8'hC3);

        // en held for 15 strobes: one overrun only.
        w = mkword(12'hFFF, 5'h1F, 8'h00);
        frame(w, 15, 1'b1, 12'hFFF, 5'h1F, 8'h00);

        // Link stalls after 5 pairs.
        frame(W_GOOD, 5, 1'b0, 12'h000, 5'h00, 8'h00);
        w = mkword(12'h001, 5'h01, 8'h80);
        frame(w, 13, 1'b1, 12'h001, 5'h01, 8'h80);

        // Reset in the middle of a frame: no pulse, everything cleared.
        for (int i = 0; i < 3; i++) begin
            rise_pair(1'b1, 1'b0, 1'b1);
            hold_high();
        end
        @(negedge clk);
        bus.trig_clk = 1'b0; bus.trig_en = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_all_zero("midreset");
        reset = 1'b0;
        m_bcid = '0; m_phi = '0; m_band = '0; m_fcnt = 0; m_ecnt = 0;
        repeat (4) @(negedge clk);

        // 20 good frames with a 4-bit counter: frame_cnt saturates at 0xF.
        for (int k = 0; k < 20; k++) begin
            logic [11:0] b;
            logic [4:0]  p;
            logic [7:0]  n;
            b = 12'h100 + 12'(k * 37);
            p = 5'(k);
            n = 8'hF0 ^ 8'(k);
            frame(mkword(b, p, n), 13, 1'b1, b, p, n);
        end
        repeat (20) @(negedge clk);
        check("frame_cnt_sat", 32'(bus.frame_cnt), 32'hF);
        check("err_cnt_final", 32'(bus.err_cnt),   32'h0);
        check("sb_drained",    32'(sb.size()),     32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
